mesh_boot_sequencer: RTL and testbench
======================================

// Module: mesh_boot_sequencer
// PURPOSE
//  Parametrised boot sequencer and output drain for the real-core mesh. Sits between top-level control
//  and real_cores_mesh: resets then starts each enabled core over a valid/ready command channel,
//  and buffers the mesh's 32-bit output stream for host reads.
//  Adds over the fixed 16-core wrapper: core count, per-core mask, command back-pressure, re-boot, 1/cycle drain, overflow count.
// PARAMETERS
//  NUM_CORES        16         cores booted, IDs 0..NUM_CORES-1
//  ID_BITS          4          core_ID width, >= clog2(NUM_CORES)
//  LOCAL_ADDR_BITS  22         per-core address window; core base = id << LOCAL_ADDR_BITS
//  ENTRY_OFFSET     32'h10     program entry offset within a window
//  ADDR_WIDTH       32         prog_address width
//  DATA_WIDTH       32         output stream width
//  FIFO_DEPTH       8          output buffer entries, power of two >= 2
//  OP_RESET/OP_START/OP_IDLE  4'b0011/4'b1010/4'b0000  operation encodings
// PORTS
//  clock         in   1            clock
//  RST           in   1            reset, synchronous, active-low
//  go            in   1            boot request; sampled in IDLE or DONE only
//  core_mask     in   NUM_CORES    bit i=1 boots core i; sampled when go is accepted
//  cmd_valid     out  1            command presented to mesh
//  cmd_ready     in   1            mesh accepts command
//  operation     out  4            command opcode
//  core_ID       out  ID_BITS      target core
//  ON/reset/start out 1 each       core power, reset and start controls
//  prog_address  out  ADDR_WIDTH   start PC
//  busy, done    out  1 each       sequence running / sequence complete
//  mesh_data     in   DATA_WIDTH   mesh output word
//  mesh_valid    in   1            mesh output strobe
//  mesh_ready    out  1            = ~full | pop
//  rd_req        in   1            host read request (level)
//  data, valid   out  DATA_WIDTH,1 buffered word and its strobe
//  overflow_cnt  out  16           saturating count of words dropped because the FIFO was full
// BEHAVIOUR
//  Reset (RST=0 at a clock edge):
//   - state=IDLE.
//   - All outputs 0, operation=OP_IDLE.
//   - FIFO emptied, overflow_cnt=0.
//   - Abandons any in-flight sequence or command.
//  FSM: IDLE -go-> RST_PH -> START_PH -> DONE.
//   - DONE -go-> RST_PH (re-boot). go is ignored while busy.
//   - Index idx starts at 0 on go.
//  RST_PH, START_PH, per idx:
//   - If core_mask_q[idx]=0: skip in exactly 1 cycle, no command.
//   - Else cmd_valid=1 with core_ID=idx, held with all fields stable until the cmd_ready cycle, then idx++.
//   - Back-to-back commands are allowed: cmd_valid may stay 1 across an accepted/next pair.
//  RST_PH command: operation=OP_RESET, ON=1, reset=1, start=0.
//  START_PH command: operation=OP_START, ON=1, reset=0, start=1,
//   prog_address = ((idx << LOCAL_ADDR_BITS) + ENTRY_OFFSET) truncated to ADDR_WIDTH.
//  Phase change: after idx=NUM_CORES-1 is handled, idx wraps to 0 and RST_PH moves to START_PH.
//  DONE:
//   - Entered after the last START_PH index.
//   - done=1, busy=0, cmd_valid=0, operation=OP_IDLE.
//   - ON and start keep their last values.
//  busy=1 in RST_PH and START_PH only. core_mask=0 completes in 2*NUM_CORES cycles with no commands.
//  FIFO:
//   - push = mesh_valid & mesh_ready; pop = rd_req & ~empty.
//   - A simultaneous push and pop when full is legal; occupancy is unchanged.
//   - data and valid are registered, 1 cycle after pop; valid is a 1-cycle pulse per word.
//   - With rd_req held, one word per cycle.
//   - mesh_valid & ~mesh_ready drops the word and increments overflow_cnt, saturating at 16'hFFFF.
//  Pointers wrap modulo FIFO_DEPTH; full/empty come from an extra wrap bit.
// STRUCTURE
//  Shared package mesh_boot_pkg: state enum {IDLE, RST_PH, START_PH, DONE} and opcode localparams.
//  One sub-module: sync_fifo #(DATA_WIDTH, FIFO_DEPTH) (push, pop, full, empty, registered read).
//  FSM, index counter and command register stay in this module.
// TESTING
//  1 NUM_CORES=16, mask=FFFF, cmd_ready=1: 16 OP_RESET then 16 OP_START commands, one per cycle;
//    core 5 prog_address=32'h1400010; done asserts 1 cycle after the last accept.
//  2 mask=16'h0005, cmd_ready low 3 cycles on each command: only cores 0 and 2 are commanded;
//    fields stay stable while stalled; 2*16 cycles of skips plus stalls.
//  3 RST low mid START_PH at idx 7: next cycle all outputs 0, IDLE; a new go restarts at OP_RESET, core 0.
//  4 go in DONE with mask=16'h8000: re-boot commands only core 15, prog_address=32'h3C00010.
//  5 Push 10 words, rd_req=0, FIFO_DEPTH=8: mesh_ready drops after 8; overflow_cnt=2;
//    then rd_req=1 gives words 0..7 on 8 consecutive valid cycles.
//  6 FIFO full with push and pop in the same cycle: word accepted, no overflow, order preserved.

Source files
------------

// File: rtl/mesh_boot_sequencer_pkg.sv
// mesh_boot_pkg
//   Shared types and constants for the mesh boot sequencer: the sequencer
//   state encoding and the command opcodes understood by real_cores_mesh.
package mesh_boot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST_PH,
    START_PH,
    DONE
  } state_t;

  localparam logic [3:0] OP_RESET = 4'b0011;
  localparam logic [3:0] OP_START = 4'b1010;
  localparam logic [3:0] OP_IDLE  = 4'b0000;

endpackage

// File: rtl/mesh_boot_sequencer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a registered read port, used to buffer the mesh
//   output stream until the host reads it.
// Ports
//   clock, RST      clock and synchronous active-low reset (empties the FIFO)
//   push, push_data write strobe and word; caller only pushes when not full or popping
//   pop             read strobe; caller only pops when not empty
//   full, empty     occupancy flags
//   rd_data         word popped on the previous cycle
//   rd_valid        one-cycle strobe qualifying rd_data
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low bits match.
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // A push and pop on a full FIFO hit the same slot: the read takes the old
  // word from mem_q while the new word lands in mem_d, so order is preserved.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = pop;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_data_d = mem_q[rd_ptr_q[PTR_W-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mesh_boot_sequencer.sv
// mesh_boot_sequencer
//   Boots the real-core mesh: on go, issues a reset command to every enabled
//   core, then a start command with that core's entry PC, over a valid/ready
//   command channel. Also buffers the mesh's output stream for host reads.
// Ports
//   clock, RST             clock and synchronous active-low reset
//   go, core_mask          boot request and per-core enable (captured on go)
//   cmd_valid, cmd_ready   command handshake towards the mesh
//   operation, core_ID     command opcode and target core
//   ON, reset, start       core power / reset / start controls
//   prog_address           start PC for OP_START commands
//   busy, done             sequence running / sequence complete
//   mesh_data/valid/ready  mesh output stream into the buffer
//   rd_req, data, valid    host read request and registered read data
//   overflow_cnt           saturating count of words dropped on a full buffer
module mesh_boot_sequencer
  import mesh_boot_pkg::*;
#(
  parameter int          NUM_CORES       = 16,
  parameter int          ID_BITS         = 4,
  parameter int          LOCAL_ADDR_BITS = 22,
  parameter logic [31:0] ENTRY_OFFSET    = 32'h10,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          FIFO_DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  RST,
  input  logic                  go,
  input  logic [NUM_CORES-1:0]  core_mask,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [3:0]            operation,
  output logic [ID_BITS-1:0]    core_ID,
  output logic                  ON,
  output logic                  reset,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] prog_address,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] mesh_data,
  input  logic                  mesh_valid,
  output logic                  mesh_ready,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [15:0]           overflow_cnt
);

  state_t                  state_q, state_d;
  logic [ID_BITS-1:0]      idx_q, idx_d;
  logic [NUM_CORES-1:0]    mask_q, mask_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [3:0]              operation_q, operation_d;
  logic [ID_BITS-1:0]      core_id_q, core_id_d;
  logic                    on_q, on_d;
  logic                    reset_q, reset_d;
  logic                    start_q, start_d;
  logic [ADDR_WIDTH-1:0]   prog_address_q, prog_address_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    advance;
  logic                    last_idx;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0]             overflow_cnt_q, overflow_cnt_d;

  function automatic logic [ADDR_WIDTH-1:0] entry_address(input logic [ID_BITS-1:0] id);
    return (ADDR_WIDTH'(id) << LOCAL_ADDR_BITS) + ADDR_WIDTH'(ENTRY_OFFSET);
  endfunction

  // Next state and index. In a phase, an index completes either because its
  // core is masked off (no command was raised) or because the mesh accepted
  // the command on this cycle.
  // The command registers are derived from the next state/index, so a command
  // is presented on the very cycle its index becomes current and stays
  // unchanged while stalled.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    mask_d         = mask_q;
    last_idx       = (idx_q == ID_BITS'(NUM_CORES - 1));
    advance        = ~cmd_valid_q | cmd_ready;

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = RST_PH;
          idx_d   = '0;
          mask_d  = core_mask;
        end
      end
      RST_PH, START_PH: begin
        if (advance) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = (state_q == RST_PH) ? START_PH : DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d    = 1'b0;
    operation_d    = OP_IDLE;
    core_id_d      = core_id_q;
    on_d           = on_q;
    reset_d        = 1'b0;
    start_d        = start_q;
    prog_address_d = prog_address_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    case (state_d)
      RST_PH: begin
        busy_d    = 1'b1;
        core_id_d = idx_d;
        if (mask_d[idx_d]) begin
          cmd_valid_d = 1'b1;
          operation_d = OP_RESET;
          on_d        = 1'b1;
          reset_d     = 1'b1;
          start_d     = 1'b0;
        end
      end
      START_PH: begin
        busy_d    = 1'b1;
        core_id_d = idx_d;
        if (mask_d[idx_d]) begin
          cmd_valid_d    = 1'b1;
          operation_d    = OP_START;
          on_d           = 1'b1;
          reset_d        = 1'b0;
          start_d        = 1'b1;
          prog_address_d = entry_address(idx_d);
        end
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!RST) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      mask_q         <= '0;
      cmd_valid_q    <= 1'b0;
      operation_q    <= OP_IDLE;
      core_id_q      <= '0;
      on_q           <= 1'b0;
      reset_q        <= 1'b0;
      start_q        <= 1'b0;
      prog_address_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      mask_q         <= mask_d;
      cmd_valid_q    <= cmd_valid_d;
      operation_q    <= operation_d;
      core_id_q      <= core_id_d;
      on_q           <= on_d;
      reset_q        <= reset_d;
      start_q        <= start_d;
      prog_address_q <= prog_address_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign operation    = operation_q;
  assign core_ID      = core_id_q;
  assign ON           = on_q;
  assign reset        = reset_q;
  assign start        = start_q;
  assign prog_address = prog_address_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // A read frees a slot in the same cycle, so a full buffer still accepts a
  // word when the host is popping.
  assign fifo_pop   = rd_req & ~fifo_empty;
  assign mesh_ready = ~fifo_full | fifo_pop;
  assign fifo_push  = mesh_valid & mesh_ready;

  always_comb begin
    overflow_cnt_d = overflow_cnt_q;
    if (mesh_valid && !mesh_ready && (overflow_cnt_q != 16'hFFFF)) begin
      overflow_cnt_d = overflow_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!RST) begin
      overflow_cnt_q <= '0;
    end else begin
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign overflow_cnt = overflow_cnt_q;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .RST      (RST),
    .push     (fifo_push),
    .push_data(mesh_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_data  (data),
    .rd_valid (valid)
  );

endmodule

// File: tb/tb_mesh_boot_sequencer.sv
// tb_mesh_boot_sequencer
//   Scoreboard bench for mesh_boot_sequencer: stimulus tasks push expected
//   commands and buffered words into queues; monitors on the falling edge pop
//   and compare whenever the DUT presents a command or a read word.
module tb_mesh_boot_sequencer;
  import mesh_boot_pkg::*;

  logic        clock = 1'b0;
  logic        RST = 1'b0;
  logic        go = 1'b0;
  logic [15:0] core_mask = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [3:0]  operation;
  logic [3:0]  core_ID;
  logic        ON, reset, start;
  logic [31:0] prog_address;
  logic        busy, done;
  logic [31:0] mesh_data = '0;
  logic        mesh_valid = 1'b0;
  logic        mesh_ready;
  logic        rd_req = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic [15:0] overflow_cnt;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  id;
    logic        on;
    logic        rst;
    logic        st;
    logic        chk_addr;
    logic [31:0] addr;
  } exp_cmd_t;

  exp_cmd_t    cmd_q[$];
  logic [31:0] data_q[$];
  int          total = 0;
  int          bad = 0;
  bit          stall_mode = 1'b0;
  int          stall_cnt = 0;

  mesh_boot_sequencer dut (
    .clock       (clock),
    .RST         (RST),
    .go          (go),
    .core_mask   (core_mask),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .operation   (operation),
    .core_ID     (core_ID),
    .ON          (ON),
    .reset       (reset),
    .start       (start),
    .prog_address(prog_address),
    .busy        (busy),
    .done        (done),
    .mesh_data   (mesh_data),
    .mesh_valid  (mesh_valid),
    .mesh_ready  (mesh_ready),
    .rd_req      (rd_req),
    .data        (data),
    .valid       (valid),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Queue the commands a boot with this mask must produce, then pulse go.
  task automatic applyStimulus(input logic [15:0] mask);
    exp_cmd_t e;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        e = '{op: OP_RESET, id: 4'(i), on: 1'b1, rst: 1'b1, st: 1'b0, chk_addr: 1'b0, addr: 32'h0};
        cmd_q.push_back(e);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        e = '{op: OP_START, id: 4'(i), on: 1'b1, rst: 1'b0, st: 1'b1, chk_addr: 1'b1,
              addr: 32'h0040_0000 * 32'(i) + 32'h10};
        cmd_q.push_back(e);
      end
    end
    core_mask = mask;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Count busy cycles until done, bounded, then check the DONE outputs.
  task automatic waitDone(input string name, input int exp_busy);
    int busy_cycles = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      tick();
    end
    checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    checkOutput({name, "_busy_in_done"}, 64'(busy), 64'd0);
    checkOutput({name, "_valid_in_done"}, 64'(cmd_valid), 64'd0);
    checkOutput({name, "_op_in_done"}, 64'(operation), 64'(OP_IDLE));
    checkOutput({name, "_cmds_left"}, 64'(cmd_q.size()), 64'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    checkOutput({name, "_operation"}, 64'(operation), 64'(OP_IDLE));
    checkOutput({name, "_core_ID"}, 64'(core_ID), 64'd0);
    checkOutput({name, "_ON"}, 64'(ON), 64'd0);
    checkOutput({name, "_reset"}, 64'(reset), 64'd0);
    checkOutput({name, "_start"}, 64'(start), 64'd0);
    checkOutput({name, "_prog_address"}, 64'(prog_address), 64'd0);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_done"}, 64'(done), 64'd0);
    checkOutput({name, "_valid"}, 64'(valid), 64'd0);
    checkOutput({name, "_data"}, 64'(data), 64'd0);
    checkOutput({name, "_overflow_cnt"}, 64'(overflow_cnt), 64'd0);
  endtask

  // Command monitor: every cycle a command is shown it must match the head
  // of the queue, so a stalled command is checked on each stalled cycle.
  initial begin
    exp_cmd_t e;
    forever begin
      @(negedge clock);
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_cmd: got op=%0h id=%0d expected none", operation, core_ID);
        end else begin
          e = cmd_q[0];
          checkOutput("cmd_op", 64'(operation), 64'(e.op));
          checkOutput("cmd_id", 64'(core_ID), 64'(e.id));
          checkOutput("cmd_on", 64'(ON), 64'(e.on));
          checkOutput("cmd_reset", 64'(reset), 64'(e.rst));
          checkOutput("cmd_start", 64'(start), 64'(e.st));
          if (e.chk_addr) checkOutput("cmd_prog_address", 64'(prog_address), 64'(e.addr));
          if (cmd_ready) void'(cmd_q.pop_front());
        end
      end
    end
  end

  // Read-data monitor.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clock);
      if (valid) begin
        if (data_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got=%0h expected none", data);
        end else begin
          w = data_q.pop_front();
          checkOutput("fifo_data", 64'(data), 64'(w));
        end
      end
    end
  end

  // Mesh-side ready: in stall mode each command sees 3 low cycles then 1 high.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!stall_mode) begin
        cmd_ready = 1'b1;
      end else if (cmd_valid) begin
        if (stall_cnt == 3) begin
          cmd_ready = 1'b1;
          stall_cnt = 0;
        end else begin
          cmd_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        cmd_ready = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    RST = 1'b0;
    repeat (2) tick();
    checkAllZero("reset");
    checkOutput("reset_mesh_ready", 64'(mesh_ready), 64'd1);
    RST = 1'b1;
    tick();

    // Full mask, always ready: 32 commands back to back.
    $display("[TB] full boot");
    applyStimulus(16'hFFFF);
    waitDone("t1", 32);
    checkOutput("t1_on_kept", 64'(ON), 64'd1);
    checkOutput("t1_start_kept", 64'(start), 64'd1);

    // Sparse mask with 3 stall cycles per command.
    $display("[TB] stalled sparse boot");
    stall_cnt  = 0;
    stall_mode = 1'b1;
    applyStimulus(16'h0005);
    waitDone("t2", 44);
    stall_mode = 1'b0;
    tick();

    // Re-boot from DONE with only core 15.
    $display("[TB] reboot core 15");
    applyStimulus(16'h8000);
    waitDone("t4", 32);

    // Reset in the middle of the start phase.
    $display("[TB] reset mid start phase");
    applyStimulus(16'hFFFF);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_valid && operation == OP_START && core_ID == 4'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("t3_reached_idx7", 64'(found), 64'd1);
    RST = 1'b0;
    cmd_q.delete();
    tick();
    checkAllZero("t3_after_reset");
    RST = 1'b1;
    tick();
    applyStimulus(16'hFFFF);
    waitDone("t3_restart", 32);

    // Ten words into an 8-deep buffer with no reads.
    $display("[TB] fifo overflow");
    for (int i = 0; i < 10; i++) begin
      mesh_valid = 1'b1;
      mesh_data  = 32'hA5A5_0000 + 32'(i);
      if (i < 8) data_q.push_back(32'hA5A5_0000 + 32'(i));
      #1;
      checkOutput("t5_mesh_ready", 64'(mesh_ready), 64'(i < 8));
      tick();
    end
    mesh_valid = 1'b0;
    checkOutput("t5_overflow_cnt", 64'(overflow_cnt), 64'd2);
    rd_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("t5_valid", 64'(valid), 64'(k <= 8));
    end
    rd_req = 1'b0;
    checkOutput("t5_words_left", 64'(data_q.size()), 64'd0);

    // Fill, then push and pop together while full.
    $display("[TB] fifo push and pop when full");
    for (int i = 0; i < 8; i++) begin
      mesh_valid = 1'b1;
      mesh_data  = 32'hC3C3_0000 + 32'(i);
      data_q.push_back(32'hC3C3_0000 + 32'(i));
      tick();
    end
    mesh_valid = 1'b0;
    #1;
    checkOutput("t6_full_not_ready", 64'(mesh_ready), 64'd0);
    mesh_valid = 1'b1;
    mesh_data  = 32'hC3C3_0008;
    rd_req     = 1'b1;
    data_q.push_back(32'hC3C3_0008);
    #1;
    checkOutput("t6_ready_on_pop", 64'(mesh_ready), 64'd1);
    tick();
    mesh_valid = 1'b0;
    checkOutput("t6_no_overflow", 64'(overflow_cnt), 64'd2);
    repeat (12) tick();
    rd_req = 1'b0;
    checkOutput("t6_words_left", 64'(data_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
